// File: rtl/jtframe_dump_sched_if.sv
// Control, configuration and status bundle of jtframe_dump_sched.
// master drives arm/abort/cfg_*; slave returns frame_cnt and the dump_* / busy / done status.
interface jtframe_dump_sched_if #(
  parameter int LENW = 16,
  parameter int FCW  = 32
);
  logic            arm;
  logic            abort;
  logic            cfg_mode;
  logic [FCW-1:0]  cfg_start;
  logic [LENW-1:0] cfg_len;
  logic [FCW-1:0]  frame_cnt;
  logic            dump_on;
  logic            dump_start;
  logic            dump_stop;
  logic            busy;
  logic            done;

  modport master (
    output arm, abort, cfg_mode, cfg_start, cfg_len,
    input  frame_cnt, dump_on, dump_start, dump_stop, busy, done
  );

  modport slave (
    input  arm, abort, cfg_mode, cfg_start, cfg_len,
    output frame_cnt, dump_on, dump_start, dump_stop, busy, done
  );
endinterface

// File: rtl/jtframe_dump_sched.sv
// Frame-based capture window scheduler (vs / downloading async pins, bus = control+status).
// Define DUMP_REARM_EN to let DONE re-enter WAIT while arm stays high.
module jtframe_dump_sched #(
  parameter int LENW = 16,
  parameter int FCW  = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vs,
  input  logic downloading,
  jtframe_dump_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAP,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // [0],[1] synchroniser, [2] previous value for edge detect
  logic [2:0] vs_sync_q, vs_sync_d;
  logic [2:0] dl_sync_q, dl_sync_d;
  logic vs_fall_q, vs_fall_d;
  logic dl_fall_q, dl_fall_d;

  logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;
  logic            mode_q, mode_d;
  logic [FCW-1:0]  start_q, start_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] left_q, left_d;

  logic dump_on_q, dump_on_d;
  logic dump_start_q, dump_start_d;
  logic dump_stop_q, dump_stop_d;

  logic load;
  logic trig;
  logic tick;
  logic last;

  always_comb begin
    vs_sync_d = {vs_sync_q[1:0], vs};
    dl_sync_d = {dl_sync_q[1:0], downloading};
    vs_fall_d = !vs_sync_q[1] && vs_sync_q[2];
    dl_fall_d = !dl_sync_q[1] && dl_sync_q[2];
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (dl_sync_q[1])
      frame_cnt_d = '0;
    else if (vs_fall_q && frame_cnt_q != '1)
      frame_cnt_d = frame_cnt_q + 1'b1;
  end

  // compares use the counter value before this frame's increment
  assign trig = mode_q ? dl_fall_q
                       : (vs_fall_q && frame_cnt_q == start_q);
  // a zero length never counts down: unbounded window
  assign tick = vs_fall_q && len_q != '0;
  assign last = tick && left_q == LENW'(1);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.arm) begin
          state_d = S_WAIT;
          load    = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.abort)
          state_d = S_IDLE;
        else if (trig)
          state_d = S_CAP;
      end
      S_CAP: begin
        if (bus.abort || last)
          state_d = S_DONE;
      end
      S_DONE: begin
`ifdef DUMP_REARM_EN
        if (bus.arm) begin
          state_d = S_WAIT;
          load    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
`else
        if (!bus.arm)
          state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mode_d  = load ? bus.cfg_mode  : mode_q;
    start_d = load ? bus.cfg_start : start_q;
    len_d   = load ? bus.cfg_len   : len_q;
    left_d  = left_q;
    if (load)
      left_d = bus.cfg_len;
    else if (state_q == S_CAP && state_d == S_CAP && tick)
      left_d = left_q - 1'b1;
  end

  // the trigger cycle itself leaves frames_left untouched
  always_comb begin
    dump_on_d    = state_d == S_CAP;
    dump_start_d = state_q == S_WAIT && state_d == S_CAP;
    dump_stop_d  = state_q == S_CAP && state_d == S_DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dump_on_q    <= 1'b0;
      dump_start_q <= 1'b0;
      dump_stop_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dump_on_q    <= dump_on_d;
      dump_start_q <= dump_start_d;
      dump_stop_q  <= dump_stop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sync_q   <= '0;
      dl_sync_q   <= '0;
      vs_fall_q   <= 1'b0;
      dl_fall_q   <= 1'b0;
      frame_cnt_q <= '0;
      mode_q      <= 1'b0;
      start_q     <= '0;
      len_q       <= '0;
      left_q      <= '0;
    end else begin
      vs_sync_q   <= vs_sync_d;
      dl_sync_q   <= dl_sync_d;
      vs_fall_q   <= vs_fall_d;
      dl_fall_q   <= dl_fall_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      start_q     <= start_d;
      len_q       <= len_d;
      left_q      <= left_d;
    end
  end

  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.dump_on    = dump_on_q;
  assign bus.dump_start = dump_start_q;
  assign bus.dump_stop  = dump_stop_q;
  assign bus.busy       = state_q == S_WAIT || state_q == S_CAP;
  assign bus.done       = state_q == S_DONE;

endmodule

// File: tb/tb_jtframe_dump_sched.sv
// Directed bench for jtframe_dump_sched: 32-bit counter instance
// for scheduling, 8-bit counter instance for saturation.
module tb_jtframe_dump_sched;

  localparam int VP = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b1;
  logic downloading = 1'b0;
  logic vs2 = 1'b1;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  int overlap = 0;
  int on_cyc = 0;

  jtframe_dump_sched_if #(.LENW(16), .FCW(32)) bus ();
  jtframe_dump_sched_if #(.LENW(16), .FCW(8))  bus2 ();

  jtframe_dump_sched #(.LENW(16), .FCW(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vs          (vs),
    .downloading (downloading),
    .bus         (bus)
  );

  jtframe_dump_sched #(.LENW(16), .FCW(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .vs          (vs2),
    .downloading (1'b0),
    .bus         (bus2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.dump_start) start_cnt <= start_cnt + 1;
    if (bus.dump_stop) stop_cnt <= stop_cnt + 1;
    if (bus.dump_start && bus.dump_stop) overlap <= overlap + 1;
    if (bus.dump_on) on_cyc <= on_cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // one vs frame; returns clk edges from pin fall to dump_start/stop (-1 = none)
  task automatic vs_frame(output int ls, output int lp);
    ls = -1;
    lp = -1;
    @(negedge clk);
    vs = 1'b0;
    for (int i = 1; i <= VP / 2; i++) begin
      @(posedge clk);
      #1;
      if (bus.dump_start && ls < 0) ls = i;
      if (bus.dump_stop && lp < 0) lp = i;
    end
    @(negedge clk);
    vs = 1'b1;
    repeat (VP / 2) @(posedge clk);
  endtask

  task automatic frames(input int n);
    int a, b;
    for (int i = 0; i < n; i++) vs_frame(a, b);
  endtask

  initial begin
    int ls, lp, s0, p0, c0;
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_mode = 1'b0;
    bus.cfg_start = '0;
    bus.cfg_len = '0;
    bus2.arm = 1'b0;
    bus2.abort = 1'b0;
    bus2.cfg_mode = 1'b0;
    bus2.cfg_start = '0;
    bus2.cfg_len = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    chk("rst_dump_on", bus.dump_on, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // mode 0, start 5, len 3
    @(negedge clk);
    bus.cfg_mode = 1'b0;
    bus.cfg_start = 5;
    bus.cfg_len = 3;
    bus.arm = 1'b1;
    @(negedge clk);
    bus.cfg_start = 2;
    bus.cfg_len = 9;
    @(posedge clk);
    #1;
    chk("m0_busy", bus.busy, 1);
    frames(5);
    chk("m0_cnt_pre", bus.frame_cnt, 5);
    chk("m0_no_early_start", start_cnt, 0);
    c0 = on_cyc;
    vs_frame(ls, lp);
    chk("m0_start_lat", ls, 4);
    chk("m0_on", bus.dump_on, 1);
    vs_frame(ls, lp);
    chk("m0_stop_f7", lp, -1);
    vs_frame(ls, lp);
    chk("m0_stop_f8", lp, -1);
    chk("m0_cnt_last", bus.frame_cnt, 8);
    vs_frame(ls, lp);
    chk("m0_stop_lat", lp, 4);
    chk("m0_on_cycles", on_cyc - c0, 3 * VP);
    chk("m0_done", bus.done, 1);
    chk("m0_busy_off", bus.busy, 0);
    chk("m0_cnt_end", bus.frame_cnt, 9);
    @(negedge clk);
    bus.arm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("m0_idle_done", bus.done, 0);

    // mode 1, len 2
    @(negedge clk);
    downloading = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("dl_cnt_clear", bus.frame_cnt, 0);
    @(negedge clk);
    bus.cfg_mode = 1'b1;
    bus.cfg_len = 2;
    bus.arm = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    downloading = 1'b0;
    ls = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.dump_start && ls < 0) ls = i;
    end
    chk("m1_start_lat", ls, 4);
    chk("m1_cnt_open", bus.frame_cnt, 0);
    vs_frame(ls, lp);
    chk("m1_no_stop1", lp, -1);
    vs_frame(ls, lp);
    chk("m1_stop_lat", lp, 4);
    chk("m1_done", bus.done, 1);
    @(negedge clk);
    bus.arm = 1'b0;
    repeat (2) @(posedge clk);

    // unbounded window ended by abort
    @(negedge clk);
    bus.cfg_mode = 1'b0;
    bus.cfg_start = 2;
    bus.cfg_len = 0;
    bus.arm = 1'b1;
    vs_frame(ls, lp);
    chk("ub_start_lat", ls, 4);
    p0 = stop_cnt;
    frames(10);
    chk("ub_on", bus.dump_on, 1);
    chk("ub_no_stop", stop_cnt - p0, 0);
    chk("ub_cnt", bus.frame_cnt, 13);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    chk("ub_stop_pulse", bus.dump_stop, 1);
    chk("ub_off", bus.dump_on, 0);
    chk("ub_done", bus.done, 1);
    @(negedge clk);
    bus.abort = 1'b0;
    @(posedge clk);
    #1;
    chk("ub_stop_once", bus.dump_stop, 0);
    frames(1);
    chk("ub_cnt_runs", bus.frame_cnt, 14);
    @(negedge clk);
    bus.arm = 1'b0;
    repeat (2) @(posedge clk);

    // abort on the trigger cycle
    @(negedge clk);
    bus.cfg_start = 14;
    bus.cfg_len = 2;
    bus.arm = 1'b1;
    repeat (2) @(posedge clk);
    s0 = start_cnt;
    p0 = stop_cnt;
    @(negedge clk);
    vs = 1'b0;
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    bus.arm = 1'b0;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("ab_no_start", start_cnt - s0, 0);
    chk("ab_no_stop", stop_cnt - p0, 0);
    chk("ab_idle_busy", bus.busy, 0);
    chk("ab_idle_done", bus.done, 0);
    chk("ab_cnt", bus.frame_cnt, 15);
    @(negedge clk);
    vs = 1'b1;
    repeat (VP / 2) @(posedge clk);

    // reset in the middle of a window
    @(negedge clk);
    bus.cfg_start = 15;
    bus.cfg_len = 4;
    bus.arm = 1'b1;
    vs_frame(ls, lp);
    chk("rs_start_lat", ls, 4);
    p0 = stop_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rs_async_off", bus.dump_on, 0);
    chk("rs_cnt", bus.frame_cnt, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rs_no_stop", stop_cnt - p0, 0);
    chk("rs_rearm_busy", bus.busy, 1);

    // abort while waiting
    s0 = start_cnt;
    @(negedge clk);
    bus.abort = 1'b1;
    bus.arm = 1'b0;
    @(negedge clk);
    bus.abort = 1'b0;
    @(posedge clk);
    #1;
    chk("aw_busy", bus.busy, 0);
    chk("aw_done", bus.done, 0);
    chk("aw_no_pulse", start_cnt - s0 + stop_cnt - p0, 0);

    // 8-bit counter saturation
    for (int i = 0; i < 254; i++) begin
      @(negedge clk);
      vs2 = 1'b0;
      repeat (4) @(negedge clk);
      vs2 = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (6) @(posedge clk);
    #1;
    chk("sat_254", bus2.frame_cnt, 254);
    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      vs2 = 1'b0;
      repeat (4) @(negedge clk);
      vs2 = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (6) @(posedge clk);
    #1;
    chk("sat_hold", bus2.frame_cnt, 255);

    chk("no_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
